// File: rtl/water_level_monitor.sv
// water_level_monitor
// Synchronises and debounces a stack of level sensors, decodes the debounced
// pattern into a tank level, flags impossible (non-thermometer) patterns and
// escalates a persistent conflict into a sticky fault that must be cleared.
//
// Handshake note: there is no valid/ready traffic here. level_valid is a
// qualifier only: level is meaningful while level_valid is high and holds its
// last good value otherwise. clear_fault is a single-cycle request that is
// sampled on the clock edge and is acted on only when it can take effect.
module water_level_monitor #(
  parameter int LEVELS        = 3,
  parameter int DEBOUNCE      = 4,
  parameter int FAULT_PERSIST = 8,
  localparam int LW           = $clog2(LEVELS + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [LEVELS-1:0] sensors,
  input  logic              clear_fault,
  output logic [LW-1:0]     level,
  output logic              level_valid,
  output logic              conflict,
  output logic              fault,
  output logic [7:0]        fault_events,
  output logic [1:0]        state_dbg
);

  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int PW = (FAULT_PERSIST > 1) ? $clog2(FAULT_PERSIST + 1) : 1;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  // Synchroniser and debouncer state
  logic [LEVELS-1:0] sync1_q, sync1_d;
  logic [LEVELS-1:0] sync2_q, sync2_d;
  logic [LEVELS-1:0] deb_q, deb_d;
  logic [DW-1:0]     db_cnt_q [LEVELS];
  logic [DW-1:0]     db_cnt_d [LEVELS];

  // Supervisory state
  state_t            state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [LW-1:0]     level_q, level_d;
  logic              level_valid_q, level_valid_d;
  logic              conflict_q, conflict_d;
  logic              fault_q, fault_d;
  logic [7:0]        events_q, events_d;

  // Decoded view of the debounced pattern
  logic              c;
  logic [LW-1:0]     pop;
  logic              enter_fault;

  // Two-flop synchroniser chain for every sensor line
  always_comb begin
    sync1_d = sensors;
    sync2_d = sync1_q;
  end

  // Per-bit debouncer: a synced bit must disagree with the accepted bit for
  // DEBOUNCE consecutive samples before it is accepted; any agreement restarts.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < LEVELS; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE - 1)) begin
          deb_d[i]    = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Pattern decode: count wet sensors and detect a wet sensor above a dry one
  always_comb begin
    pop = '0;
    for (int i = 0; i < LEVELS; i++) begin
      pop = pop + LW'(deb_q[i]);
    end
    c = |(deb_q[LEVELS-1:1] & ~deb_q[LEVELS-2:0]);
  end

  // Next-state logic for the supervisory FSM and its registered outputs
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    level_d     = level_q;
    events_d    = events_q;
    enter_fault = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (!c) begin
          level_d = pop;
        end else if (FAULT_PERSIST == 1) begin
          state_d     = ST_FAULT;
          pc_d        = '0;
          enter_fault = 1'b1;
        end else begin
          state_d = ST_SUSPECT;
          pc_d    = PW'(1);
        end
      end
      ST_SUSPECT: begin
        if (!c) begin
          state_d = ST_NORMAL;
          pc_d    = '0;
          level_d = pop;
        end else if (pc_q + PW'(1) == PW'(FAULT_PERSIST)) begin
          state_d     = ST_FAULT;
          pc_d        = '0;
          enter_fault = 1'b1;
        end else begin
          pc_d = pc_q + PW'(1);
        end
      end
      ST_FAULT: begin
        // A clear request during an ongoing conflict is dropped, not queued.
        if (clear_fault && !c) begin
          state_d = ST_NORMAL;
          pc_d    = '0;
          level_d = pop;
        end
      end
      default: begin
        state_d = ST_NORMAL;
        pc_d    = '0;
      end
    endcase
    if (enter_fault && (events_q != 8'hff)) begin
      events_d = events_q + 8'd1;
    end
    level_valid_d = (state_d == ST_NORMAL);
    fault_d       = (state_d == ST_FAULT);
    conflict_d    = c;
  end

  // All state registers; reset returns every flop to its idle value at once
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      deb_q         <= '0;
      for (int i = 0; i < LEVELS; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q       <= ST_NORMAL;
      pc_q          <= '0;
      level_q       <= '0;
      level_valid_q <= 1'b1;
      conflict_q    <= 1'b0;
      fault_q       <= 1'b0;
      events_q      <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_q         <= deb_d;
      for (int i = 0; i < LEVELS; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q       <= state_d;
      pc_q          <= pc_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      conflict_q    <= conflict_d;
      fault_q       <= fault_d;
      events_q      <= events_d;
    end
  end

  assign level        = level_q;
  assign level_valid  = level_valid_q;
  assign conflict     = conflict_q;
  assign fault        = fault_q;
  assign fault_events = events_q;
  assign state_dbg    = state_q;

endmodule
